pipe_stage_skid: RTL and testbench

Generic parametrised pipeline stage register for the processor datapath, with valid/ready flow control, synchronous flush (bubble insertion) and an optional one-entry skid buffer. It replaces the fixed per-stage registers between IF/ID/EX/MEM/WB. Each stage's field bundle is packed into `in_data` (payload) and `in_ctrl` (control bits that must read zero in a bubble). This gives stall, flush and back-pressure in one reusable block.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_skid_if.sv | 26 ++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_FULL  = 2'd1;
    localparam logic [1:0] LVL_SKID  = 2'd2;

    function automatic logic [1:0] state_level(input pipe_state_t s);
        case (s)
            ST_FULL: return LVL_FULL;
            ST_SKID: return LVL_SKID;
            default: return LVL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle of one pipeline stage.
// A transfer happens on a rising edge where valid && ready; valid must not depend on ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        level;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, level
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, level
    );
endinterface

// File: rtl/pipe_slot.sv
// One storage entry (valid, data, ctrl). clear wins over load; drop invalidates but keeps data.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              drop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= in_valid;
            q_data  <= in_data;
            q_ctrl  <= in_ctrl;
        end else if (drop) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, flush and an optional skid entry.
// M always drives the outputs; S only catches the entry in flight when M stalls.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    pipe_stage_skid_if.slave bus
);

    pipe_state_t       state_q, state_d;
    logic              acc, pop;
    logic              m_load, m_from_s, m_drop, m_clear;
    logic              s_load, s_clear;
    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;

    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_from_s = 1'b0;
        m_drop   = 1'b0;
        m_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (FLUSH) begin
            // an entry accepted this cycle is swallowed along with the stored ones
            state_d = ST_EMPTY;
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        m_load  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (acc && pop) begin
                        m_load = 1'b1;
                    end else if (acc && (SKID != 0)) begin
                        s_load  = 1'b1;
                        state_d = ST_SKID;
                    end else if (pop) begin
                        m_drop  = 1'b1;
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                        state_d  = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (m_load),
        .clear    (m_clear),
        .drop     (m_drop),
        .in_valid (m_from_s ? s_valid : bus.in_valid),
        .in_data  (m_from_s ? s_data  : bus.in_data),
        .in_ctrl  (m_from_s ? s_ctrl  : bus.in_ctrl),
        .q_valid  (m_valid),
        .q_data   (m_data),
        .q_ctrl   (m_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk      (CLK),
                .rst_n    (RESET_N),
                .load     (s_load),
                .clear    (s_clear),
                .drop     (1'b0),
                .in_valid (bus.in_valid),
                .in_data  (bus.in_data),
                .in_ctrl  (bus.in_ctrl),
                .q_valid  (s_valid),
                .q_data   (s_data),
                .q_ctrl   (s_ctrl)
            );
            // decoded from the state flop only: no path from out_ready
            assign bus.in_ready = RESET_N && (state_q != ST_SKID);
        end else begin : g_noskid
            logic unused_skid;
            assign unused_skid  = s_load | s_clear;
            assign s_valid      = 1'b0;
            assign s_data       = '0;
            assign s_ctrl       = '0;
            assign bus.in_ready = RESET_N && (!m_valid || bus.out_ready);
        end
    endgenerate

    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data;
    assign bus.out_ctrl  = m_valid ? m_ctrl : '0;
    assign bus.level     = state_level(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed scoreboard bench for pipe_stage_skid, SKID=1 and SKID=0 instances side by side.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int W  = DW + CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b1 ();
    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b0 ();

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .bus(b1.slave)
    );
    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .bus(b0.slave)
    );

    logic [W-1:0] exp1_q[$];
    logic [W-1:0] exp0_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle of stimulus on the SKID=1 stage; returns 1 time unit after the edge
    task automatic drv1(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        b1.in_valid  = v;
        b1.in_data   = d;
        b1.in_ctrl   = c;
        b1.out_ready = ordy;
        flush        = fl;
        #1;
        if (v && b1.in_ready && !fl) exp1_q.push_back({d, c});
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        b0.in_valid  = v;
        b0.in_data   = d;
        b0.in_ctrl   = c;
        b0.out_ready = ordy;
        flush        = fl;
        #1;
        check("noskid_in_ready", b0.in_ready, !b0.out_valid || b0.out_ready);
        if (v && b0.in_ready && !fl) exp0_q.push_back({d, c});
        @(posedge clk);
        #1;
    endtask

    // monitors: pop and compare whenever an output transfer is presented
    always @(negedge clk) begin
        if (rst_n) begin
            if (b1.out_valid && b1.out_ready) begin
                if (exp1_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL skid_unexpected_out: got %0h expected nothing", {b1.out_data, b1.out_ctrl});
                end else begin
                    check("skid_out", {b1.out_data, b1.out_ctrl}, exp1_q.pop_front());
                end
            end
            if (!b1.out_valid) check("skid_bubble_ctrl", b1.out_ctrl, '0);
            if (flush) exp1_q.delete();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.out_valid && b0.out_ready) begin
                if (exp0_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL noskid_unexpected_out: got %0h expected nothing", {b0.out_data, b0.out_ctrl});
                end else begin
                    check("noskid_out", {b0.out_data, b0.out_ctrl}, exp0_q.pop_front());
                end
            end
            if (!b0.out_valid) check("noskid_bubble_ctrl", b0.out_ctrl, '0);
            if (flush) exp0_q.delete();
        end
    end

    initial begin
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_ctrl = '0; b1.out_ready = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.in_ctrl = '0; b0.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_low", b1.in_ready, 1'b0);
        check("rst_level", b1.level, 2'd0);
        check("rst_out_valid", b1.out_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_high", b1.in_ready, 1'b1);

        // streaming 1..4 with out_ready high
        for (int i = 1; i <= 4; i++) begin
            drv1(1'b1, i, 16'h0001, 1'b1, 1'b0);
            check("stream_data", b1.out_data, i);
            check("stream_level", b1.level, 2'd1);
        end
        drv1(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_drain_level", b1.level, 2'd0);

        // skid: stall with two entries, then release
        drv1(1'b1, 32'h10, 16'h00F0, 1'b0, 1'b0);
        check("skid_l1_data", b1.out_data, 32'h10);
        check("skid_l1_level", b1.level, 2'd1);
        drv1(1'b1, 32'h11, 16'h00F1, 1'b0, 1'b0);
        check("skid_l2_level", b1.level, 2'd2);
        check("skid_l2_in_ready", b1.in_ready, 1'b0);
        check("skid_l2_data", b1.out_data, 32'h10);
        drv1(1'b1, 32'h12, 16'h00F2, 1'b0, 1'b0);
        check("skid_hold_level", b1.level, 2'd2);
        check("skid_hold_data", b1.out_data, 32'h10);
        drv1(1'b0, '0, '0, 1'b1, 1'b0);
        check("skid_rel_data", b1.out_data, 32'h11);
        check("skid_rel_level", b1.level, 2'd1);
        drv1(1'b0, '0, '0, 1'b1, 1'b0);
        check("skid_rel_empty", b1.level, 2'd0);

        // bubble gating: stale ctrl in M must not leak while invalid
        drv1(1'b1, 32'h70, 16'hFFFF, 1'b1, 1'b0);
        check("gate_valid_ctrl", b1.out_ctrl, 16'hFFFF);
        repeat (4) begin
            drv1(1'b0, 32'h71, 16'hFFFF, 1'b1, 1'b0);
            check("gate_bubble_ctrl", b1.out_ctrl, '0);
            check("gate_bubble_valid", b1.out_valid, 1'b0);
        end

        // flush with a simultaneous accept
        drv1(1'b1, 32'h30, 16'h0030, 1'b0, 1'b0);
        check("flush_pre_level", b1.level, 2'd1);
        drv1(1'b1, 32'h31, 16'hABCD, 1'b0, 1'b1);
        check("flush_out_valid", b1.out_valid, 1'b0);
        check("flush_out_ctrl", b1.out_ctrl, '0);
        check("flush_level", b1.level, 2'd0);
        check("flush_in_ready", b1.in_ready, 1'b1);

        // flush from level 2
        drv1(1'b1, 32'h20, 16'h0001, 1'b0, 1'b0);
        drv1(1'b1, 32'h21, 16'h0002, 1'b0, 1'b0);
        check("flush2_pre_level", b1.level, 2'd2);
        drv1(1'b1, 32'h22, 16'h0003, 1'b0, 1'b1);
        check("flush2_level", b1.level, 2'd0);
        check("flush2_out_valid", b1.out_valid, 1'b0);
        drv1(1'b1, 32'h40, 16'h0004, 1'b1, 1'b0);
        check("flush_resume_data", b1.out_data, 32'h40);
        check("flush_resume_valid", b1.out_valid, 1'b1);
        // pop in the flush cycle completes, the accepted entry is discarded
        drv1(1'b1, 32'h41, 16'h0005, 1'b1, 1'b0);
        drv1(1'b1, 32'h42, 16'h0006, 1'b1, 1'b1);
        check("flush_pop_level", b1.level, 2'd0);
        drv1(1'b0, '0, '0, 1'b1, 1'b0);

        // asynchronous reset at level 2, mid-cycle
        drv1(1'b1, 32'h50, 16'h0007, 1'b0, 1'b0);
        drv1(1'b1, 32'h51, 16'h0008, 1'b0, 1'b0);
        check("arst_pre_level", b1.level, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", b1.out_valid, 1'b0);
        check("arst_out_data", b1.out_data, '0);
        check("arst_out_ctrl", b1.out_ctrl, '0);
        check("arst_level", b1.level, 2'd0);
        check("arst_in_ready", b1.in_ready, 1'b0);
        exp1_q.delete();
        exp0_q.delete();
        b1.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_in_ready", b1.in_ready, 1'b1);
        drv1(1'b1, 32'hA5, 16'h00A5, 1'b0, 1'b0);
        check("arst_first_valid", b1.out_valid, 1'b1);
        check("arst_first_data", b1.out_data, 32'hA5);
        drv1(1'b0, '0, '0, 1'b1, 1'b0);
        check("arst_drain_level", b1.level, 2'd0);

        // SKID=0 regression with random out_ready / in_valid
        for (int n = 0; n < 300; n++) begin
            drv0(1'($urandom_range(0, 1)), 32'h1000 + n, 16'(n) ^ 16'h5A5A,
                 1'($urandom_range(0, 1)), 1'b0);
            check("noskid_level_max", b0.level > 2'd1, 1'b0);
        end
        repeat (3) drv0(1'b0, '0, '0, 1'b1, 1'b0);
        check("noskid_queue_empty", exp0_q.size(), 0);
        check("skid_queue_empty", exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
